// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the two-requester SRAM arbiter:
//   - state_t : FSM state encoding (IDLE, SETUP, ACCESS, DONE), also exported
//               on the top-level debug port.
//   - DEF_ADDR_W / DEF_DATA_W / DEF_ACCESS_CYCLES : default parameter values.
// Optional feature macro used by the files that import this package:
//   SRAM_ARB_RR_EN -> round-robin arbitration instead of fixed priority.
// ---------------------------------------------------------------------------
package sram_arb_pkg;

  localparam int DEF_ADDR_W        = 11;
  localparam int DEF_DATA_W        = 8;
  localparam int DEF_ACCESS_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage : sram_arb_pkg

// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
// Requester-side bus of the SRAM arbiter. Two requesters share it; requester
// i owns bit i of every 2-bit vector and slice i of the packed address/data.
//
// Handshake: a requester raises reqValid[i] together with reqWrite[i],
// reqAddr slice i and reqWrData slice i. The transfer is accepted in the
// cycle where reqValid[i] && reqReady[i] are both high at the rising clock
// edge; the request fields are captured at that edge. reqValid may be
// dropped at any time before acceptance without side effects. Completion is
// a single-cycle rspValid[i] pulse; for reads rdData is valid in that cycle
// and holds afterwards until the next read completes.
//
// Signals:
//   reqValid  [1:0]          requester -> arbiter
//   reqReady  [1:0]          arbiter   -> requester
//   reqWrite  [1:0]          requester -> arbiter (1=write, 0=read)
//   reqAddr   [2*ADDR_W-1:0] requester -> arbiter
//   reqWrData [2*DATA_W-1:0] requester -> arbiter
//   rspValid  [1:0]          arbiter   -> requester
//   rdData    [DATA_W-1:0]   arbiter   -> requester
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);

  logic [1:0]          reqValid;
  logic [1:0]          reqReady;
  logic [1:0]          reqWrite;
  logic [2*ADDR_W-1:0] reqAddr;
  logic [2*DATA_W-1:0] reqWrData;
  logic [1:0]          rspValid;
  logic [DATA_W-1:0]   rdData;

  modport master (
    output reqValid,
    output reqWrite,
    output reqAddr,
    output reqWrData,
    input  reqReady,
    input  rspValid,
    input  rdData
  );

  modport slave (
    input  reqValid,
    input  reqWrite,
    input  reqAddr,
    input  reqWrData,
    output reqReady,
    output rspValid,
    output rdData
  );

endinterface : sram_arbiter_if

// File: rtl/sram_arb_select.sv
// ---------------------------------------------------------------------------
// sram_arb_select
// Grant selection between the two requesters.
//   Default build    : fixed priority, requester 0 wins whenever it is valid.
//   SRAM_ARB_RR_EN   : round-robin; when both are valid the grant goes to the
//                      requester that did not win the previous handshake.
//                      lastGrant resets to 1 so requester 0 wins first.
// Ports:
//   clk, rst  (SRAM_ARB_RR_EN only) clock and synchronous active-high reset
//   i_hs      (SRAM_ARB_RR_EN only) handshake strobe, updates lastGrant
//   i_valid   per-requester request valid
//   o_grant   combinational grant ID (0 or 1)
// ---------------------------------------------------------------------------
module sram_arb_select (
`ifdef SRAM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       i_hs,
`endif
  input  logic [1:0] i_valid,
  output logic       o_grant
);

`ifdef SRAM_ARB_RR_EN
  logic r_last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (i_hs) begin
      r_last_grant <= o_grant;
    end
  end

  always_comb begin
    o_grant = 1'b0;
    if (i_valid == 2'b11) begin
      o_grant = ~r_last_grant;
    end else begin
      o_grant = (i_valid == 2'b10);
    end
  end
`else
  // Requester 1 only wins when requester 0 is not asking.
  assign o_grant = i_valid[1] & ~i_valid[0];
`endif

endmodule : sram_arb_select

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Arbitrates two requesters onto one asynchronous SRAM port. Each accepted
// request runs IDLE -> SETUP (1 cycle) -> ACCESS (ACCESS_CYCLES cycles) ->
// DONE (1 cycle, rspValid pulse) -> IDLE. All SRAM pins are registered.
// Optional feature: define SRAM_ARB_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
// Parameters:
//   ACCESS_CYCLES  cycles enable is held low per access (1..15)
//   ADDR_W         SRAM address width
//   DATA_W         SRAM data width
// Ports:
//   clk          clock
//   rst          synchronous active-high reset (aborts any access in flight)
//   req_bus      requester bus (sram_arbiter_if.slave)
//   chipSelect   SRAM chip select, active-low
//   enable       SRAM output/write enable, active-low
//   readnWrite   1=read, 0=write
//   address      SRAM address
//   sramDataIn   write data to SRAM (0 during reads)
//   sramDataOut  read data from SRAM
//   o_dbg_state  current FSM state
// ---------------------------------------------------------------------------
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  sram_arbiter_if.slave       req_bus,
  output logic                chipSelect,
  output logic                enable,
  output logic                readnWrite,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   sramDataIn,
  input  logic [DATA_W-1:0]   sramDataOut,
  output state_t              o_dbg_state
);

  // Counter value seen during the final ACCESS cycle.
  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic               r_gnt_id;
  logic               r_cs;
  logic               r_en;
  logic               r_rnw;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_din;
  logic [DATA_W-1:0]  r_rd;
  logic [1:0]         r_rsp;

  logic               w_grant;
  logic [1:0]         w_ready;
  logic               w_hs;
  logic               w_sel_write;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;

  // ---------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------
  sram_arb_select u_select (
`ifdef SRAM_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
    .i_hs    (w_hs),
`endif
    .i_valid (req_bus.reqValid),
    .o_grant (w_grant)
  );

  // reqReady is combinational so a requester that drops reqValid before the
  // edge is never accepted; it is forced low during reset.
  always_comb begin
    w_ready = 2'b00;
    if (r_state == IDLE && !rst) begin
      if (w_grant) begin
        w_ready = {req_bus.reqValid[1], 1'b0};
      end else begin
        w_ready = {1'b0, req_bus.reqValid[0]};
      end
    end
  end

  assign w_hs = |w_ready;

  // Request fields of the granted requester.
  always_comb begin
    w_sel_write = req_bus.reqWrite[0];
    w_sel_addr  = req_bus.reqAddr[ADDR_W-1:0];
    w_sel_data  = req_bus.reqWrData[DATA_W-1:0];
    if (w_grant) begin
      w_sel_write = req_bus.reqWrite[1];
      w_sel_addr  = req_bus.reqAddr[2*ADDR_W-1:ADDR_W];
      w_sel_data  = req_bus.reqWrData[2*DATA_W-1:DATA_W];
    end
  end

  // ---------------------------------------------------------------------
  // Access FSM. Every SRAM pin is a register updated on the transition
  // into the state in which it must take its new value.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_gnt_id <= 1'b0;
      r_cs     <= 1'b1;
      r_en     <= 1'b1;
      r_rnw    <= 1'b1;
      r_addr   <= '0;
      r_din    <= '0;
      r_rd     <= '0;
      r_rsp    <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp <= 2'b00;
          if (w_hs) begin
            r_state  <= SETUP;
            r_gnt_id <= w_grant;
            r_rnw    <= ~w_sel_write;
            r_addr   <= w_sel_addr;
            // Data bus is driven to zero for reads.
            r_din    <= w_sel_write ? w_sel_data : '0;
            r_cs     <= 1'b0;
            r_en     <= 1'b1;
          end
        end
        SETUP: begin
          r_state <= ACCESS;
          r_en    <= 1'b0;
          r_cnt   <= 4'd0;
        end
        ACCESS: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= DONE;
            r_en    <= 1'b1;
            if (r_rnw) begin
              r_rd <= sramDataOut;
            end
            r_rsp <= r_gnt_id ? 2'b10 : 2'b01;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cs    <= 1'b1;
          r_rsp   <= 2'b00;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign req_bus.reqReady = w_ready;
  assign req_bus.rspValid = r_rsp;
  assign req_bus.rdData   = r_rd;

  assign chipSelect  = r_cs;
  assign enable      = r_en;
  assign readnWrite  = r_rnw;
  assign address     = r_addr;
  assign sramDataIn  = r_din;
  assign o_dbg_state = r_state;

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
// Self-checking bench for sram_arbiter. dut_a (ACCESS_CYCLES=2) is checked
// every cycle against a transaction-level model that tracks the age of the
// current access; dut_b (ACCESS_CYCLES=1) covers back-to-back reads.
// Build with SRAM_ARB_RR_EN defined to check the round-robin variant.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int AC = 2;
  localparam int AW = 11;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A (ACCESS_CYCLES=2) ----------------
  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  logic          cs_a, en_a, rnw_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] din_a, dout_a;
  state_t        st_a;

  sram_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(AW), .DATA_W(DW)) dut_a (
    .clk(clk), .rst(rst), .req_bus(bus_a),
    .chipSelect(cs_a), .enable(en_a), .readnWrite(rnw_a),
    .address(addr_a), .sramDataIn(din_a), .sramDataOut(dout_a),
    .o_dbg_state(st_a)
  );

  // ---------------- DUT B (ACCESS_CYCLES=1) ----------------
  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();
  logic          cs_b, en_b, rnw_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] din_b, dout_b;
  state_t        st_b;

  sram_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(AW), .DATA_W(DW)) dut_b (
    .clk(clk), .rst(rst), .req_bus(bus_b),
    .chipSelect(cs_b), .enable(en_b), .readnWrite(rnw_b),
    .address(addr_b), .sramDataIn(din_b), .sramDataOut(dout_b),
    .o_dbg_state(st_b)
  );

  // ---------------- SRAM environment ----------------
  logic [DW-1:0] sram_mem [2**AW];
  logic [DW-1:0] ref_mem  [2**AW];
  assign dout_a = sram_mem[addr_a];
  always @(posedge clk) begin
    if (!rst && cs_a === 1'b0 && en_a === 1'b0 && rnw_a === 1'b0) sram_mem[addr_a] = din_a;
  end
  assign dout_b = addr_b[7:0] ^ 8'h5A;

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model of dut_a ----------------
  // m_age counts cycles since the handshake: 0 = setup, 1..AC = access,
  // AC+1 = completion cycle.
  bit            m_on   = 0;
  bit            m_busy = 0;
  int            m_age  = 0;
  logic          m_id   = 1'b0;
  logic          m_last = 1'b1;
  logic          m_rnw  = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din  = '0;
  logic [DW-1:0] m_rd   = '0;
  logic [DW-1:0] exp_q[$];

  function automatic logic pick(input logic [1:0] v, input logic last);
`ifdef SRAM_ARB_RR_EN
    if (v == 2'b11) return ~last;
    return (v == 2'b10);
`else
    return (v == 2'b10) ^ (last & 1'b0);
`endif
  endfunction

  always @(posedge clk) begin
    logic g;
    cyc++;
    if (rst) begin
      m_on = 1; m_busy = 0; m_age = 0; m_last = 1'b1;
      m_rnw = 1'b1; m_addr = '0; m_din = '0; m_rd = '0;
      exp_q.delete();
    end else if (m_on) begin
      if (m_busy) begin
        m_age++;
        if (m_age == 2 && !m_rnw) ref_mem[m_addr] = m_din;
        if (m_age == AC + 1 && m_rnw) m_rd = ref_mem[m_addr];
        if (m_age == AC + 2) m_busy = 0;
      end else begin
        g = pick(bus_a.reqValid, m_last);
        if (bus_a.reqValid[g] === 1'b1) begin
          m_busy = 1; m_age = 0; m_id = g; m_last = g;
          m_rnw  = ~bus_a.reqWrite[g];
          m_addr = bus_a.reqAddr[int'(g)*AW +: AW];
          if (m_rnw) begin
            m_din = '0;
            exp_q.push_back(ref_mem[m_addr]);
          end else begin
            m_din = bus_a.reqWrData[int'(g)*DW +: DW];
          end
        end
      end
    end
  end

  // ---------------- monitors ----------------
  int   hs_cyc = 0, rsp_cyc = 0, rsp_cnt_a = 0;
  logic [1:0] rsp_vec = '0;
  logic [DW-1:0] rsp_data = '0;
  int   cs_cnt = 0, en_cnt = 0, wr_cnt = 0;
  logic glog[$];
  int   hs_b_cyc = 0, rsp_b_cnt = 0;
  int   rsp_b_cyc[$];
  logic [DW-1:0] rsp_b_data[$];
  logic [AW-1:0] rsp_b_addr[$];

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    state_t     es;
    logic [1:0] er, ev, hs;
    logic       g;
    if (m_on) begin
      es = !m_busy ? IDLE : (m_age == 0 ? SETUP : (m_age <= AC ? ACCESS : DONE));
      g  = pick(bus_a.reqValid, m_last);
      er = (!m_busy && !rst) ? (bus_a.reqValid & (g ? 2'b10 : 2'b01)) : 2'b00;
      ev = (m_busy && m_age == AC + 1) ? (m_id ? 2'b10 : 2'b01) : 2'b00;
      chk("state",      st_a,           es);
      chk("reqReady",   bus_a.reqReady, er);
      chk("rspValid",   bus_a.rspValid, ev);
      chk("chipSelect", cs_a,           !m_busy);
      chk("enable",     en_a,           !(m_busy && m_age >= 1 && m_age <= AC));
      chk("readnWrite", rnw_a,          m_rnw);
      chk("address",    addr_a,         m_addr);
      chk("sramDataIn", din_a,          m_din);
      chk("rdData",     bus_a.rdData,   m_rd);
      if (bus_a.rspValid !== 2'b00 && rnw_a === 1'b1) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk("rd_scoreboard", bus_a.rdData, exp_q.pop_front());
      end
    end
    hs = bus_a.reqValid & bus_a.reqReady;
    if (hs == 2'b01 || hs == 2'b10) begin hs_cyc = cyc; glog.push_back(hs[1]); end
    if (bus_a.rspValid == 2'b01 || bus_a.rspValid == 2'b10) begin
      rsp_cyc = cyc; rsp_vec = bus_a.rspValid; rsp_data = bus_a.rdData; rsp_cnt_a++;
    end
    if (cs_a === 1'b0) cs_cnt++;
    if (en_a === 1'b0) en_cnt++;
    if (cs_a === 1'b0 && rnw_a === 1'b0) wr_cnt++;
    if ((bus_b.reqValid & bus_b.reqReady) != 2'b00) hs_b_cyc = cyc;
    if (bus_b.rspValid == 2'b01 || bus_b.rspValid == 2'b10) begin
      rsp_b_cnt++; rsp_b_cyc.push_back(cyc);
      rsp_b_data.push_back(bus_b.rdData); rsp_b_addr.push_back(addr_b);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_a(input int r, input bit v, input bit w, input int addr, input int data);
    bus_a.reqValid[r]          = v;
    bus_a.reqWrite[r]          = w;
    bus_a.reqAddr[r*AW +: AW]  = AW'(addr);
    bus_a.reqWrData[r*DW +: DW] = DW'(data);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_hs_a(input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); #1;
      if ((bus_a.reqValid & bus_a.reqReady) != 2'b00) begin ok = 1; break; end
    end
    if (!ok) chk("hs_timeout_a", 0, 1);
  endtask

  task automatic wait_rsp_a(input int lim);
    int start = rsp_cnt_a;
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); #1;
      if (rsp_cnt_a > start) begin ok = 1; break; end
    end
    if (!ok) chk("rsp_timeout_a", 0, 1);
  endtask

  task automatic wait_hs_b(input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); #1;
      if ((bus_b.reqValid & bus_b.reqReady) != 2'b00) begin ok = 1; break; end
    end
    if (!ok) chk("hs_timeout_b", 0, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int t, r0, t1, t2, n_hs;
    logic exp_g[$];
    logic [DW-1:0] v;
    for (int i = 0; i < 2**AW; i++) begin
      v = DW'($urandom);
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    bus_a.reqValid = '0; bus_a.reqWrite = '0; bus_a.reqAddr = '0; bus_a.reqWrData = '0;
    bus_b.reqValid = '0; bus_b.reqWrite = '0; bus_b.reqAddr = '0; bus_b.reqWrData = '0;

    // Reset values, with both requesters asking (ready must stay low).
    rst = 1'b1;
    bus_a.reqValid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_chipSelect", cs_a, 1);
    chk("rst_enable",     en_a, 1);
    chk("rst_readnWrite", rnw_a, 1);
    chk("rst_address",    addr_a, 0);
    chk("rst_sramDataIn", din_a, 0);
    chk("rst_rdData",     bus_a.rdData, 0);
    chk("rst_rspValid",   bus_a.rspValid, 0);
    chk("rst_reqReady",   bus_a.reqReady, 0);
    chk("rst_state",      st_a, IDLE);
    next_cycle();
    bus_a.reqValid = 2'b00;
    rst = 1'b0;
    next_cycle();

    // Requester 0 writes 0xA5 to 0x123.
    cs_cnt = 0; en_cnt = 0;
    drive_a(0, 1, 1, 'h123, 'hA5);
    wait_hs_a(10);
    t = hs_cyc;
    next_cycle();
    bus_a.reqValid[0] = 1'b0;
    wait_rsp_a(20);
    chk("wr_rsp_latency", rsp_cyc - t, 4);
    chk("wr_rsp_vec",     rsp_vec, 2'b01);
    chk("wr_cs_low",      cs_cnt, 4);
    chk("wr_en_low",      en_cnt, 2);
    chk("wr_sram_cell",   sram_mem[11'h123], 8'hA5);
    next_cycle();

    // Requester 1 reads 0x123 back.
    wr_cnt = 0;
    drive_a(1, 1, 0, 'h123, 'h00);
    wait_hs_a(10);
    t = hs_cyc;
    next_cycle();
    bus_a.reqValid[1] = 1'b0;
    wait_rsp_a(20);
    chk("rd_rsp_latency", rsp_cyc - t, 4);
    chk("rd_rsp_vec",     rsp_vec, 2'b10);
    chk("rd_data",        rsp_data, 8'hA5);
    chk("rd_rnw_low",     wr_cnt, 0);
    next_cycle();

    // Both requesters valid continuously.
    glog.delete();
`ifdef SRAM_ARB_RR_EN
    n_hs = 4; exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    n_hs = 3; exp_g = '{1'b0, 1'b0, 1'b0};
`endif
    drive_a(0, 1, 0, 'h004, 0);
    drive_a(1, 1, 0, 'h005, 0);
    for (int i = 0; i < n_hs; i++) wait_hs_a(12);
    next_cycle();
    bus_a.reqValid = 2'b00;
    chk("grant_count", glog.size(), n_hs);
    for (int i = 0; i < n_hs; i++) begin
      if (i < glog.size()) chk($sformatf("grant_%0d", i), glog[i], exp_g[i]);
    end
    repeat (6) next_cycle();

    // Reset pulsed in the middle of an access.
    drive_a(0, 1, 0, 'h010, 0);
    wait_hs_a(10);
    next_cycle();                 // setup cycle
    bus_a.reqValid[0] = 1'b0;
    next_cycle();                 // access cycle
    rst = 1'b1;
    r0 = rsp_cnt_a;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_chipSelect", cs_a, 1);
    chk("abort_enable",     en_a, 1);
    chk("abort_state",      st_a, IDLE);
    chk("abort_rspValid",   bus_a.rspValid, 0);
    repeat (6) @(negedge clk);
    chk("abort_no_rsp",     rsp_cnt_a, r0);
    next_cycle();

    // dut_b: back-to-back reads of 0x000 then 0x7FF.
    bus_b.reqWrite[0] = 1'b0;
    bus_b.reqAddr[AW-1:0] = '0;
    bus_b.reqValid[0] = 1'b1;
    wait_hs_b(10);
    t1 = hs_b_cyc;
    next_cycle();
    bus_b.reqAddr[AW-1:0] = 11'h7FF;
    wait_hs_b(10);
    t2 = hs_b_cyc;
    next_cycle();
    bus_b.reqValid[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_hs_gap", t2 - t1, 4);
    chk("b2b_rsp_count", rsp_b_cnt, 2);
    if (rsp_b_cnt >= 2) begin
      chk("b2b_rsp0_latency", rsp_b_cyc[0] - t1, 3);
      chk("b2b_rd0",   rsp_b_data[0], 8'h5A);
      chk("b2b_addr0", rsp_b_addr[0], 11'h000);
      chk("b2b_rd1",   rsp_b_data[1], 8'hA5);
      chk("b2b_addr1", rsp_b_addr[1], 11'h7FF);
    end

    // Randomized traffic on dut_a, checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      for (int r = 0; r < 2; r++) begin
        drive_a(r, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                $urandom_range(0, 15), $urandom_range(0, 255));
      end
    end
    next_cycle();
    bus_a.reqValid = 2'b00;
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sram_arbiter

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter ACCESS_CYCLES, default 2, meaning cycles the SRAM enable is held asserted per access (legal 1..15).
REQ-002 The block SHALL have parameter ADDR_W, default 11, meaning SRAM address width.
REQ-003 The block SHALL have parameter DATA_W, default 8, meaning SRAM data width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The ports SHALL be:
- clk  in  1  the single clock.
- rst  in  1  synchronous active-high reset.
- reqValid  in  2  per-requester request valid.
- reqReady  out  2  per-requester request accepted.
- reqWrite  in  2  per-requester access type; 1=write, 0=read.
- reqAddr  in  2*ADDR_W  packed addresses; requester i in slice i.
- reqWrData  in  2*DATA_W  packed write data.
- rspValid  out  2  one-cycle completion pulse per requester.
- rdData  out  DATA_W  read data, valid with rspValid.
- chipSelect  out  1  SRAM chip select, active-low.
- enable  out  1  SRAM output/write enable, active-low.
- readnWrite  out  1  1=read, 0=write.
- address  out  ADDR_W  SRAM address.
- sramDataIn  out  DATA_W  write data to SRAM.
- sramDataOut  in  DATA_W  read data from SRAM.

Function
REQ-006 The FSM SHALL have states IDLE, SETUP, ACCESS, DONE.
REQ-007 In IDLE, reqReady SHALL be high only for the granted requester, and only when that requester's reqValid is high; a handshake (reqValid&reqReady) SHALL latch write, address, write data and grant ID, then move to SETUP.
REQ-008 SETUP SHALL last 1 cycle: chipSelect=0, enable=1, address/readnWrite/sramDataIn driven from latched values.
REQ-009 ACCESS SHALL last exactly ACCESS_CYCLES cycles with chipSelect=0 and enable=0; a 4-bit counter SHALL count the cycles.
REQ-010 On the last ACCESS cycle of a read, sramDataOut SHALL be registered into rdData.
REQ-011 DONE SHALL last 1 cycle: enable=1, chipSelect=0, rspValid[grant]=1; the next state SHALL be IDLE.
REQ-012 For a handshake at cycle T, rspValid SHALL pulse at T+2+ACCESS_CYCLES; the next handshake SHALL occur no earlier than T+3+ACCESS_CYCLES.
REQ-013 In IDLE, chipSelect=1, enable=1, and reqReady SHALL be 0 in all other states.
REQ-014 address, readnWrite and sramDataIn SHALL be stable from SETUP through DONE; sramDataIn SHALL be 0 for reads.
REQ-015 rdData SHALL hold its last value until the next read completes; writes SHALL NOT change it.
REQ-016 Dropping reqValid before the handshake SHALL be legal and SHALL have no effect.
REQ-017 A requester SHALL NOT be granted twice in succession while the other is waiting (with SRAM_ARB_RR_EN).

Reset
REQ-018 While rst=1 at a clock edge: state=IDLE, chipSelect=1, enable=1, readnWrite=1, address=0, sramDataIn=0, rdData=0, rspValid=0, reqReady=0, counter=0, lastGrant=1.
REQ-019 Reset during SETUP/ACCESS/DONE SHALL abort the access with no rspValid pulse.

Configuration
REQ-020 With SRAM_ARB_RR_EN defined, the arbiter SHALL be round-robin: if both are valid, grant SHALL go to ~lastGrant; lastGrant SHALL update on each handshake.
REQ-021 Without SRAM_ARB_RR_EN, requester 0 SHALL always have priority, and lastGrant SHALL be absent.

Structure
REQ-022 Package sram_arb_pkg SHALL hold the state enum type and default ADDR_W/DATA_W constants.
REQ-023 Grant selection SHALL be a sub-module sram_arb_select (combinational grant plus the lastGrant register).

Verification
REQ-024 Requester 0 writes 0xA5 to address 0x123, ACCESS_CYCLES=2 -> chipSelect low for 4 cycles, enable low for 2 cycles, rspValid[0] at T+4.
REQ-025 Requester 1 reads 0x123 with sramDataOut model returning 0xA5 -> rdData=0xA5 with rspValid[1] at T+4, readnWrite=1 throughout.
REQ-026 Both requesters valid continuously, RR build -> grants 0,1,0,1; fixed build -> grants 0,0,0.
REQ-027 rst pulsed during ACCESS -> next cycle chipSelect=1, enable=1, state IDLE, no rspValid.
REQ-028 ACCESS_CYCLES=1 with back-to-back reads of 0x000 and 0x7FF -> handshakes 4 cycles apart, address wraps correctly, rdData matches the model.
